// File: rtl/rom_stream_arbiter_pkg.sv
// Shared types for the two-requester ROM stream arbiter.
// FSM encoding and buffer entry sizing.
package rom_stream_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int TAG_W = 2;

  function automatic int entry_w(input int dw);
    return dw + TAG_W;
  endfunction

endpackage

// File: rtl/rom_stream_arbiter_if.sv
// Request, ROM and stream signals of the ROM stream arbiter.
// slave = arbiter side, master = requesters/ROM/sink side.
interface rom_stream_arbiter_if #(
  parameter int AWIDTH = 7,
  parameter int DWIDTH = 8,
  parameter int LWIDTH = 7
);
  logic              req0_valid;
  logic              req0_ready;
  logic [AWIDTH-1:0] req0_addr;
  logic [LWIDTH-1:0] req0_len;
  logic              req1_valid;
  logic              req1_ready;
  logic [AWIDTH-1:0] req1_addr;
  logic [LWIDTH-1:0] req1_len;
  logic [AWIDTH-1:0] rom_addr;
  logic              rom_en;
  logic [DWIDTH-1:0] rom_q;
  logic [DWIDTH-1:0] dout;
  logic              dout_id;
  logic              dout_last;
  logic              dout_valid;
  logic              dout_ready;
  logic              busy;

  modport slave (
    input  req0_valid, req0_addr, req0_len,
    input  req1_valid, req1_addr, req1_len,
    input  rom_q, dout_ready,
    output req0_ready, req1_ready,
    output rom_addr, rom_en,
    output dout, dout_id, dout_last, dout_valid,
    output busy
  );

  modport master (
    output req0_valid, req0_addr, req0_len,
    output req1_valid, req1_addr, req1_len,
    output rom_q, dout_ready,
    input  req0_ready, req1_ready,
    input  rom_addr, rom_en,
    input  dout, dout_id, dout_last, dout_valid,
    input  busy
  );
endinterface

// File: rtl/rom_skid_fifo.sv
// Two-entry valid/ready FIFO with fall-through when empty.
// count reports stored entries for upstream credit.
module rom_skid_fifo #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic [1:0]   count
);
  logic [W-1:0] mem0_q, mem1_q;
  logic [1:0]   cnt_q;
  logic         rd_q, wr_q;
  logic         empty, bypass, push, pop;

  assign empty  = cnt_q == 2'd0;
  assign bypass = empty & in_valid & out_ready;
  assign push   = in_valid & (cnt_q != 2'd2) & ~bypass;
  assign pop    = out_ready & ~empty;

  assign out_valid = ~empty | in_valid;
  assign count     = cnt_q;

  always_comb begin
    out_data = '0;
    if (!empty)
      out_data = rd_q ? mem1_q : mem0_q;
    else if (in_valid)
      out_data = in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem0_q <= '0;
    else if (push & ~wr_q) mem0_q <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem1_q <= '0;
    else if (push & wr_q) mem1_q <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 2'd0;
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_q + 2'(push) - 2'(pop);
      if (push) wr_q <= ~wr_q;
      if (pop)  rd_q <= ~rd_q;
    end
  end
endmodule

// File: rtl/rom_stream_arbiter.sv
// Round-robin job arbiter and read sequencer for one sync ROM.
// Streams job bytes tagged with requester id and end-of-job.
module rom_stream_arbiter
  import rom_stream_arbiter_pkg::*;
#(
  parameter int AWIDTH = 7,
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 105,
  parameter int LWIDTH = 7
) (
  input logic                 clk,
  input logic                 rst_n,
  rom_stream_arbiter_if.slave bus
);
  localparam int EW = entry_w(DWIDTH);
  localparam logic [AWIDTH:0] DEPTH_E = (AWIDTH+1)'(DEPTH);

  state_t state_q, state_d;

  logic              rr_q, run_q, id_q;
  logic [AWIDTH-1:0] ptr_q;
  logic [AWIDTH:0]   end_q;
  logic              pend_q, pend_id_q, pend_last_q;

  logic              win, acc, nonempty;
  logic              issue, is_last, credit_ok;
  logic              ready0, ready1;
  logic [AWIDTH-1:0] sel_addr;
  logic [LWIDTH-1:0] sel_len;
  logic [AWIDTH:0]   sum, end_c;
  logic [1:0]        used, fifo_cnt;
  logic              fifo_valid, fire, last_fire;
  logic [EW-1:0]     fifo_in, fifo_out;

  assign win = (bus.req0_valid & bus.req1_valid)
             ? rr_q : bus.req1_valid;
  assign acc = (state_q == IDLE) & run_q
             & (bus.req0_valid | bus.req1_valid);

  assign sel_addr = win ? bus.req1_addr : bus.req0_addr;
  assign sel_len  = win ? bus.req1_len  : bus.req0_len;
  assign sum      = {1'b0, sel_addr} + (AWIDTH+1)'(sel_len);
  assign end_c    = (sum > DEPTH_E) ? DEPTH_E : sum;
  assign nonempty = end_c > {1'b0, sel_addr};

  // reads in flight plus stored bytes never exceed the 2 buffer slots
  assign used      = {1'b0, pend_q} + fifo_cnt;
  assign credit_ok = used <= 2'd1;
  assign issue     = (state_q == ISSUE) & credit_ok;
  assign is_last   = ({1'b0, ptr_q} + 1'b1) == end_q;

  assign fire      = fifo_valid & bus.dout_ready;
  assign last_fire = fire & fifo_out[0];

  always_comb begin
    state_d = state_q;
    ready0  = 1'b0;
    ready1  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (acc) begin
          ready0 = ~win;
          ready1 = win;
          if (nonempty) state_d = ISSUE;
        end
      end
      ISSUE: if (issue & is_last) state_d = DRAIN;
      DRAIN: if (last_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_q        <= 1'b0;
      run_q       <= 1'b0;
      id_q        <= 1'b0;
      ptr_q       <= '0;
      end_q       <= '0;
      pend_q      <= 1'b0;
      pend_id_q   <= 1'b0;
      pend_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      pend_q  <= issue;
      if (acc) rr_q <= ~win;
      if (acc & nonempty) begin
        ptr_q <= sel_addr;
        end_q <= end_c;
        id_q  <= win;
      end
      if (issue) begin
        pend_id_q   <= id_q;
        pend_last_q <= is_last;
        if (!is_last) ptr_q <= ptr_q + 1'b1;
      end
    end
  end

  assign fifo_in = {bus.rom_q, pend_id_q, pend_last_q};

  rom_skid_fifo #(
    .W(EW)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (pend_q),
    .in_data  (fifo_in),
    .out_valid(fifo_valid),
    .out_data (fifo_out),
    .out_ready(bus.dout_ready),
    .count    (fifo_cnt)
  );

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.rom_en     = issue;
  assign bus.rom_addr   = ptr_q;
  assign bus.dout       = fifo_out[EW-1:2];
  assign bus.dout_id    = fifo_out[1];
  assign bus.dout_last  = fifo_out[0];
  assign bus.dout_valid = fifo_valid;
  assign bus.busy       = state_q != IDLE;
endmodule

// File: tb/tb_rom_stream_arbiter.sv
// Bench for rom_stream_arbiter: queue model of expected bytes,
// round-robin tracking and a per-cycle compare process.
module tb_rom_stream_arbiter;
  localparam int AW = 7;
  localparam int DW = 8;
  localparam int DEPTH = 105;
  localparam int LW = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] rom_q_r = 8'h00;
  logic rdy_r = 1'b1;

  rom_stream_arbiter_if #(.AWIDTH(AW), .DWIDTH(DW), .LWIDTH(LW)) bus();

  rom_stream_arbiter #(
    .AWIDTH(AW), .DWIDTH(DW), .DEPTH(DEPTH), .LWIDTH(LW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_val(input int a);
    return 8'(a * 37 + 11);
  endfunction

  assign bus.rom_q = rom_q_r;
  assign bus.dout_ready = rdy_r;

  always @(posedge clk)
    if (bus.rom_en) rom_q_r <= rom_val(int'(bus.rom_addr));

  int rdy_mode = 0;
  int ph = 0;
  always @(posedge clk) begin
    #1;
    ph = (ph + 1) % 3;
    case (rdy_mode)
      0: rdy_r = 1'b1;
      1: rdy_r = (ph == 0);
      default: rdy_r = 1'($urandom_range(0, 1));
    endcase
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [7:0] d;
    bit id;
    bit last;
  } exp_t;

  exp_t q[$];
  bit win_log[$];
  logic [7:0] flog[$];
  bit m_rr;
  int outs, cyc;
  bit idle_b, f0, f1, fr, w, ew, pstall;
  int ea, el, eend;
  logic [10:0] pbits;
  exp_t e;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_rr = 1'b0;
      outs = 0;
      cyc = 0;
      pstall = 1'b0;
    end else begin
      cyc++;
      idle_b = q.size() == 0;
      f0 = bus.req0_valid & bus.req0_ready;
      f1 = bus.req1_valid & bus.req1_ready;
      fr = bus.dout_valid & bus.dout_ready;
      if (pstall)
        chk("hold", {bus.dout_valid, bus.dout, bus.dout_id,
                     bus.dout_last}, pbits);
      if (bus.rom_en)
        chk("rom_addr_range", 32'(bus.rom_addr < DEPTH), 1);
      outs = outs + int'(bus.rom_en) - int'(fr);
      if (bus.rom_en)
        chk("outstanding", 32'(outs <= 2), 1);
      if (fr) begin
        chk("byte_expected", 32'(q.size() != 0), 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("dout", {bus.dout, bus.dout_id, bus.dout_last},
              {e.d, e.id, e.last});
        end
        flog.push_back(bus.dout);
      end
      if (idle_b && cyc >= 2 && (bus.req0_valid | bus.req1_valid))
        chk("accept_live", 32'(bus.req0_ready | bus.req1_ready), 1);
      if (bus.req0_ready | bus.req1_ready) begin
        chk("ready_no_valid",
            32'((bus.req0_ready & ~bus.req0_valid) |
                (bus.req1_ready & ~bus.req1_valid)), 0);
        chk("one_ready", 32'(bus.req0_ready & bus.req1_ready), 0);
        chk("accept_idle", 32'(idle_b), 1);
      end
      if (f0 | f1) begin
        w = f1;
        ew = (bus.req0_valid & bus.req1_valid) ? m_rr
                                               : bus.req1_valid;
        chk("winner", 32'(w), 32'(ew));
        win_log.push_back(w);
        m_rr = ~w;
        ea = w ? int'(bus.req1_addr) : int'(bus.req0_addr);
        el = w ? int'(bus.req1_len) : int'(bus.req0_len);
        eend = ea + el;
        if (eend > DEPTH) eend = DEPTH;
        for (int k = ea; k < eend; k++) begin
          e.d = rom_val(k);
          e.id = w;
          e.last = (k == eend - 1);
          q.push_back(e);
        end
      end
      pstall = bus.dout_valid & ~bus.dout_ready;
      pbits = {bus.dout_valid, bus.dout, bus.dout_id, bus.dout_last};
    end
  end

  task automatic all_zero(input string tag);
    chk({tag, "_rom_en"}, 32'(bus.rom_en), 0);
    chk({tag, "_rom_addr"}, 32'(bus.rom_addr), 0);
    chk({tag, "_dout"}, 32'(bus.dout), 0);
    chk({tag, "_dout_id"}, 32'(bus.dout_id), 0);
    chk({tag, "_dout_last"}, 32'(bus.dout_last), 0);
    chk({tag, "_dout_valid"}, 32'(bus.dout_valid), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_ready0"}, 32'(bus.req0_ready), 0);
    chk({tag, "_ready1"}, 32'(bus.req1_ready), 0);
  endtask

  task automatic run_reqs(input bit u0, input int a0, input int l0,
                          input bit u1, input int a1, input int l1);
    int n;
    bit d0, d1;
    n = 0;
    bus.req0_addr = 7'(a0);
    bus.req0_len = 7'(l0);
    bus.req1_addr = 7'(a1);
    bus.req1_len = 7'(l1);
    bus.req0_valid = u0;
    bus.req1_valid = u1;
    while ((bus.req0_valid || bus.req1_valid) && n < 400) begin
      @(negedge clk);
      d0 = bus.req0_valid & bus.req0_ready;
      d1 = bus.req1_valid & bus.req1_ready;
      @(posedge clk);
      #1;
      if (d0) bus.req0_valid = 1'b0;
      if (d1) bus.req1_valid = 1'b0;
      n++;
    end
    if (bus.req0_valid || bus.req1_valid) begin
      chk("req_timeout", 0, 1);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    bit ok;
    n = 0;
    ok = 1'b0;
    while (!ok && n < 2000) begin
      @(negedge clk);
      n++;
      ok = (q.size() == 0) && !bus.busy && !bus.dout_valid;
    end
    if (!ok) chk("idle_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  bit exp_w[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    int n;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_addr = '0;
    bus.req0_len = '0;
    bus.req1_addr = '0;
    bus.req1_len = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // contention: both valid from reset, four pairs
    for (int i = 0; i < 4; i++)
      run_reqs(1'b1, i * 10, 3, 1'b1, i * 10 + 5, 3);
    wait_idle();
    chk("rr_pairs_n", 32'(win_log.size()), 8);
    for (int i = 0; i < 8 && i < win_log.size(); i++)
      chk("rr_pairs", 32'(win_log[i]), 32'(i % 2));

    // single job with literal timing
    bus.req0_addr = 7'd0;
    bus.req0_len = 7'd5;
    bus.req0_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.req0_ready && n < 50);
    if (!bus.req0_ready) chk("single_accept", 0, 1);
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    @(negedge clk);
    chk("t1_rom_en", 32'(bus.rom_en), 1);
    chk("t1_rom_addr", 32'(bus.rom_addr), 0);
    @(negedge clk);
    chk("t2_valid", 32'(bus.dout_valid), 1);
    chk("t2_dout", 32'(bus.dout), 32'h0b);
    chk("t2_id", 32'(bus.dout_id), 0);
    chk("t2_last", 32'(bus.dout_last), 0);
    repeat (4) @(negedge clk);
    chk("t6_dout", 32'(bus.dout), 32'h9f);
    chk("t6_last", 32'(bus.dout_last), 1);
    @(negedge clk);
    chk("t7_busy", 32'(bus.busy), 0);
    chk("t7_valid", 32'(bus.dout_valid), 0);
    wait_idle();

    // backpressure
    rdy_mode = 1;
    flog.delete();
    run_reqs(1'b0, 0, 0, 1'b1, 20, 8);
    wait_idle();
    chk("bp_toggle_n", 32'(flog.size()), 8);
    if (flog.size() > 0) chk("bp_toggle_first", 32'(flog[0]), 32'hef);
    rdy_mode = 2;
    flog.delete();
    run_reqs(1'b1, 60, 8, 1'b0, 0, 0);
    wait_idle();
    chk("bp_rand_n", 32'(flog.size()), 8);
    if (flog.size() == 8) begin
      chk("bp_rand_first", 32'(flog[0]), 32'hb7);
      chk("bp_rand_last", 32'(flog[7]), 32'hba);
    end

    // boundary clip at DEPTH
    rdy_mode = 0;
    flog.delete();
    run_reqs(1'b1, 100, 10, 1'b0, 0, 0);
    wait_idle();
    chk("clip_n", 32'(flog.size()), 5);
    if (flog.size() == 5) begin
      chk("clip_first", 32'(flog[0]), 32'h7f);
      chk("clip_last", 32'(flog[4]), 32'h13);
    end

    // empty jobs still advance rr
    flog.delete();
    win_log.delete();
    run_reqs(1'b0, 0, 0, 1'b1, 3, 0);
    run_reqs(1'b1, 0, 2, 1'b1, 10, 2);
    wait_idle();
    run_reqs(1'b1, 110, 5, 1'b0, 0, 0);
    run_reqs(1'b1, 30, 1, 1'b1, 40, 1);
    wait_idle();
    chk("empty_bytes", 32'(flog.size()), 6);
    chk("empty_wins_n", 32'(win_log.size()), 6);
    for (int i = 0; i < 6 && i < win_log.size(); i++)
      chk("empty_rr", 32'(win_log[i]), 32'(exp_w[i]));

    // randomized jobs, overlapping requests
    for (int it = 0; it < 40; it++) begin
      int u;
      rdy_mode = int'($urandom_range(0, 2));
      u = int'($urandom_range(1, 3));
      run_reqs(u[0], int'($urandom_range(0, 127)),
               int'($urandom_range(0, 24)),
               u[1], int'($urandom_range(0, 127)),
               int'($urandom_range(0, 24)));
    end
    wait_idle();

    // reset in the middle of a long job
    rdy_mode = 0;
    run_reqs(1'b1, 10, 20, 1'b0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_issuing", 32'(bus.busy), 1);
    bus.req1_addr = 7'd50;
    bus.req1_len = 7'd4;
    bus.req1_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    all_zero("midrst");
    repeat (2) @(negedge clk);
    bus.req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    flog.delete();
    run_reqs(1'b0, 0, 0, 1'b1, 50, 4);
    wait_idle();
    chk("post_rst_n", 32'(flog.size()), 4);
    if (flog.size() > 0) chk("post_rst_first", 32'(flog[0]), 32'h45);
    chk("model_drained", 32'(q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
